niosii_soc_irq_ctrl: RTL and testbench



---
 rtl/niosii_soc_irq_ctrl.sv | 128 ++++++++++++
 tb/tb_niosii_soc_irq_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/niosii_soc_irq_ctrl.sv
// Avalon-MM interrupt aggregator: per-line enable, level/edge mode, edge latching,
// priority report and registered CPU irq. Define IRQ_CTRL_SYNC_EN to add a 2-flop input synchronizer.
module niosii_soc_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               cpu_irq
);

  localparam logic [15:0] VALID_MASK = 16'((32'd1 << NUM_IRQ) - 32'd1);

  localparam logic [2:0] ADDR_RAW     = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_ENABLE  = 3'd2;
  localparam logic [2:0] ADDR_MODE    = 3'd3;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
  localparam logic [2:0] ADDR_SET     = 3'd5;

  logic [15:0] irqExt;
  logic [15:0] irqS;
  logic [15:0] irqPrev_q;
  logic [15:0] enable_q, enable_d;
  logic [15:0] mode_q, mode_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] readdata_q, readdata_d;
  logic        cpuIrq_q, cpuIrq_d;
  logic [15:0] pending;
  logic [15:0] hit;
  logic [15:0] active;
  logic [3:0]  activeIdx;
  logic        wrEn;
  logic [15:0] wrMasked;

  always_comb begin
    irqExt = '0;
    irqExt[NUM_IRQ-1:0] = irq_in;
  end

`ifdef IRQ_CTRL_SYNC_EN
  logic [15:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irqExt;
      sync2_q <= sync1_q;
    end
  end

  assign irqS = sync2_q;
`else
  assign irqS = irqExt;
`endif

  assign wrEn     = chipselect & ~write_n;
  assign wrMasked = writedata & VALID_MASK;

  // Level lines report the live input; edge lines report the latched event.
  assign pending = (pend_q & mode_q) | (irqS & ~mode_q & VALID_MASK);
  assign hit     = pending & enable_q;

  always_comb begin
    activeIdx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (hit[i]) activeIdx = 4'(i);
    end
    active = (|hit) ? {1'b1, 11'd0, activeIdx} : 16'd0;
  end

  // Set wins over clear; a mode change wipes the latch of every bit that switched.
  always_comb begin
    logic [15:0] rise;
    logic [15:0] setBits;
    logic [15:0] clrBits;
    logic [15:0] modeChanged;
    rise        = irqS & ~irqPrev_q;
    setBits     = (wrEn && address == ADDR_SET)     ? wrMasked : 16'd0;
    clrBits     = (wrEn && address == ADDR_PENDING) ? wrMasked : 16'd0;
    modeChanged = (wrEn && address == ADDR_MODE)    ? (wrMasked ^ mode_q) : 16'd0;
    enable_d    = (wrEn && address == ADDR_ENABLE)  ? wrMasked : enable_q;
    mode_d      = (wrEn && address == ADDR_MODE)    ? wrMasked : mode_q;
    pend_d      = ((pend_q & ~clrBits) | rise | setBits) & mode_q & VALID_MASK & ~modeChanged;
    cpuIrq_d    = |hit;
  end

  always_comb begin
    readdata_d = 16'd0;
    case (address)
      ADDR_RAW:     readdata_d = irqS & VALID_MASK;
      ADDR_PENDING: readdata_d = pending;
      ADDR_ENABLE:  readdata_d = enable_q;
      ADDR_MODE:    readdata_d = mode_q;
      ADDR_ACTIVE:  readdata_d = active;
      default:      readdata_d = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqPrev_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      pend_q     <= '0;
      readdata_q <= '0;
      cpuIrq_q   <= 1'b0;
    end else begin
      irqPrev_q  <= irqS;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      readdata_q <= readdata_d;
      cpuIrq_q   <= cpuIrq_d;
    end
  end

  assign readdata = readdata_q;
  assign cpu_irq  = cpuIrq_q;

endmodule

// File: tb/tb_niosii_soc_irq_ctrl.sv
// Directed self-checking bench for niosii_soc_irq_ctrl with hand-computed register values.
module tb_niosii_soc_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [7:0]  irq_in;
  logic [15:0] readdata;
  logic        cpu_irq;

  int total = 0;
  int bad   = 0;
  logic [15:0] rd;

  niosii_soc_irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .irq_in     (irq_in),
    .readdata   (readdata),
    .cpu_irq    (cpu_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic readReg(input logic [2:0] a, output logic [15:0] data);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
    data = readdata;
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [15:0] data);
    address    = a;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 16'd0; irq_in = 8'd0;
    #12;
    checkOutput("reset_cpu_irq", {15'd0, cpu_irq}, 16'd0);
    checkOutput("reset_readdata", readdata, 16'd0);
    reset_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      readReg(3'(a), rd);
      checkOutput($sformatf("reset_read_addr%0d", a), rd, 16'd0);
    end

    // Level line 0
    writeReg(3'd2, 16'h0001);
    irq_in = 8'h01;
    ticks(D);
    readReg(3'd0, rd);  checkOutput("level_raw", rd, 16'h0001);
    readReg(3'd1, rd);  checkOutput("level_pending", rd, 16'h0001);
    checkOutput("level_cpu_irq_on", {15'd0, cpu_irq}, 16'd1);
    irq_in = 8'h00;
    ticks(D + 2);
    checkOutput("level_cpu_irq_off", {15'd0, cpu_irq}, 16'd0);
    readReg(3'd1, rd);  checkOutput("level_pending_off", rd, 16'h0000);

    // Edge line 1 pulse, then W1C
    writeReg(3'd3, 16'h0002);
    writeReg(3'd2, 16'h0002);
    irq_in = 8'h02; tick(); irq_in = 8'h00;
    ticks(D + 1);
    readReg(3'd1, rd);  checkOutput("edge1_pending", rd, 16'h0002);
    readReg(3'd4, rd);  checkOutput("edge1_active", rd, 16'h8001);
    checkOutput("edge1_cpu_irq", {15'd0, cpu_irq}, 16'd1);
    writeReg(3'd1, 16'h0002);
    tick();
    checkOutput("edge1_w1c_cpu_irq", {15'd0, cpu_irq}, 16'd0);
    readReg(3'd1, rd);  checkOutput("edge1_w1c_pending", rd, 16'h0000);

    // Priority across lines 2 and 5; bits above NUM_IRQ ignored
    writeReg(3'd2, 16'hFFFF);
    readReg(3'd2, rd);  checkOutput("enable_mask_width", rd, 16'h00FF);
    writeReg(3'd3, 16'h00FF);
    irq_in = 8'h24; tick(); irq_in = 8'h00;
    ticks(D + 1);
    readReg(3'd4, rd);  checkOutput("prio_active_2", rd, 16'h8002);
    writeReg(3'd1, 16'h0004);
    readReg(3'd4, rd);  checkOutput("prio_active_5", rd, 16'h8005);
    writeReg(3'd1, 16'h0020);
    readReg(3'd4, rd);  checkOutput("prio_active_none", rd, 16'h0000);
    tick();
    checkOutput("prio_cpu_irq_off", {15'd0, cpu_irq}, 16'd0);

    // Rising edge and W1C in the same cycle: set wins
    irq_in = 8'h08;
    ticks(D);
    writeReg(3'd1, 16'h0008);
    irq_in = 8'h00;
    readReg(3'd1, rd);  checkOutput("set_wins", rd, 16'h0008);

    // SET on a level bit has no effect; level bit follows input
    writeReg(3'd3, 16'h00EF);
    writeReg(3'd5, 16'h0010);
    readReg(3'd1, rd);  checkOutput("set_level_ignored", rd, 16'h0008);
    irq_in = 8'h10;
    ticks(D);
    readReg(3'd1, rd);  checkOutput("level4_follows", rd, 16'h0018);
    writeReg(3'd5, 16'h0040);
    readReg(3'd1, rd);  checkOutput("set_edge6", rd, 16'h0058);
    readReg(3'd5, rd);  checkOutput("set_reads_zero", rd, 16'h0000);

    // Level->edge switch with line high produces no event
    writeReg(3'd3, 16'h00FF);
    readReg(3'd1, rd);  checkOutput("mode_switch_no_event", rd, 16'h0048);
    writeReg(3'd6, 16'hFFFF);
    readReg(3'd6, rd);  checkOutput("addr6_zero", rd, 16'h0000);

    // Enable does not gate capture
    writeReg(3'd2, 16'h0000);
    tick();
    checkOutput("disabled_cpu_irq", {15'd0, cpu_irq}, 16'd0);
    readReg(3'd4, rd);  checkOutput("disabled_active", rd, 16'h0000);
    writeReg(3'd2, 16'h0040);
    tick();
    checkOutput("enabled_cpu_irq", {15'd0, cpu_irq}, 16'd1);
    readReg(3'd4, rd);  checkOutput("enabled_active", rd, 16'h8006);

    // Asynchronous reset mid-operation
    irq_in = 8'h00;
    address = 3'd1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_cpu_irq", {15'd0, cpu_irq}, 16'd0);
    checkOutput("midreset_readdata", readdata, 16'd0);
    #3 reset_n = 1'b1;
    tick();
    readReg(3'd1, rd);  checkOutput("post_reset_pending", rd, 16'h0000);
    readReg(3'd2, rd);  checkOutput("post_reset_enable", rd, 16'h0000);
    readReg(3'd3, rd);  checkOutput("post_reset_mode", rd, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
